// File: rtl/seq_div_pkg.sv
// Shared types, default sizing and saturation-limit helpers for the
// fixed-point sequential divider.
package seq_div_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam int unsigned NDef    = 14;
  localparam int unsigned DecDef  = 4;
  localparam int unsigned IterDef = NDef + DecDef;
  localparam int unsigned CntWDef = $clog2(IterDef + 1);

  function automatic int unsigned iter_count(input int unsigned n, input int unsigned dec);
    return n + dec;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned dec);
    return $clog2(n + dec + 1);
  endfunction

  function automatic logic [63:0] umax_lim(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] smax_lim(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative signed value.
  function automatic logic [63:0] smin_mag(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/seq_div_fx_if.sv
// Operand/result handshake bundle for seq_div_fx.
interface seq_div_fx_if #(
  parameter int unsigned N = 14
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         in_signed;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dz;
  logic         ovf;

  modport master (
    output in_valid, dividend, divisor, in_signed, abort, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, in_signed, abort, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );
endinterface

// File: rtl/div_core_iter.sv
// One combinational restoring-division step: shift {acc,sr} left, subtract
// the divisor when it fits and record a quotient bit in the sr LSB.
module div_core_iter #(
  parameter int unsigned N = 14,
  parameter int unsigned W = 18
) (
  input  logic [N:0]   acc_i,
  input  logic [W-1:0] sr_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   acc_o,
  output logic [W-1:0] sr_o
);
  logic [N:0]   acc_sh;
  logic [W-1:0] sr_sh;
  logic         fits;

  always_comb begin
    acc_sh = {acc_i[N-1:0], sr_i[W-1]};
    sr_sh  = {sr_i[W-2:0], 1'b0};
    // A set acc MSB means the shifted value is past 2^(N+1), so it always fits.
    fits   = acc_i[N] | (acc_sh >= {1'b0, dvs_i});
    acc_o  = acc_sh;
    sr_o   = sr_sh;
    if (fits) begin
      acc_o   = acc_sh - {1'b0, dvs_i};
      sr_o[0] = 1'b1;
    end
  end
endmodule

// File: rtl/seq_div_fx.sv
// Multi-cycle restoring divider: fixed-point quotient with DEC fractional bits,
// signed/unsigned per operation, divide-by-zero and saturation flags.
module seq_div_fx
  import seq_div_pkg::*;
#(
  parameter int unsigned N         = 14,
  parameter int unsigned DEC       = 4,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  seq_div_fx_if.slave  bus
);
  localparam int unsigned W    = iter_count(N, DEC);
  localparam int unsigned CntW = cnt_width(N, DEC);

  localparam logic [W-1:0] UMax    = W'(umax_lim(N));
  localparam logic [W-1:0] SMax    = W'(smax_lim(N));
  localparam logic [W-1:0] SMinMag = W'(smin_mag(N));

  state_e          state_q, state_d;
  logic [N:0]      acc_q, acc_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic            sgn_q, sgn_d;
  logic            dneg_q, dneg_d;
  logic            qneg_q, qneg_d;
  logic            dzf_q, dzf_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;

  logic [N:0]      acc_nx;
  logic [W-1:0]    sr_nx;

  div_core_iter #(
    .N(N),
    .W(W)
  ) u_core (
    .acc_i(acc_q),
    .sr_i (sr_q),
    .dvs_i(dvs_q),
    .acc_o(acc_nx),
    .sr_o (sr_nx)
  );

  logic         mode_in, dvd_neg_in, dvs_neg_in;
  logic [N-1:0] dvd_mag_in, dvs_mag_in;
  logic [W-1:0] lim;
  logic         ovf_raw;
  logic [N-1:0] mag_sat, quo_fix, quo_dz, rem_mag, rem_fix;

  always_comb begin
    mode_in    = SIGNED_EN & bus.in_signed;
    dvd_neg_in = mode_in & bus.dividend[N-1];
    dvs_neg_in = mode_in & bus.divisor[N-1];
    // Negating -2^(N-1) wraps to 2^(N-1), which is the correct unsigned magnitude.
    dvd_mag_in = dvd_neg_in ? (~bus.dividend + 1'b1) : bus.dividend;
    dvs_mag_in = dvs_neg_in ? (~bus.divisor + 1'b1) : bus.divisor;

    lim        = !sgn_q ? UMax : (qneg_q ? SMinMag : SMax);
    ovf_raw    = sr_q > lim;
    mag_sat    = ovf_raw ? lim[N-1:0] : sr_q[N-1:0];
    quo_fix    = qneg_q ? (~mag_sat + 1'b1) : mag_sat;
    quo_dz     = !sgn_q ? UMax[N-1:0] : (dneg_q ? SMinMag[N-1:0] : SMax[N-1:0]);
    // On divide-by-zero the original dividend magnitude still sits in sr.
    rem_mag    = dzf_q ? sr_q[W-1:DEC] : acc_q[N-1:0];
    rem_fix    = dneg_q ? (~rem_mag + 1'b1) : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    dneg_d  = dneg_q;
    qneg_d  = qneg_q;
    dzf_d   = dzf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          acc_d   = '0;
          sr_d    = {dvd_mag_in, {DEC{1'b0}}};
          cnt_d   = '0;
          dvs_d   = dvs_mag_in;
          sgn_d   = mode_in;
          dneg_d  = dvd_neg_in;
          qneg_d  = dvd_neg_in ^ dvs_neg_in;
          dzf_d   = (bus.divisor == '0);
          // Divide-by-zero skips the iterations; FIX forms its fixed result.
          state_d = (bus.divisor == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_nx;
          sr_d  = sr_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(W - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          quo_d   = dzf_q ? quo_dz : quo_fix;
          rem_d   = rem_fix;
          dz_d    = dzf_q;
          ovf_d   = !dzf_q & ovf_raw;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      dneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      dzf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      dneg_q  <= dneg_d;
      qneg_q  <= qneg_d;
      dzf_q   <= dzf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
endmodule
